// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Moore-FSM controller for a multi-cycle RISC-V datapath.
//                Sequences fetch/decode/execute/memory/writeback with a
//                memory wait-state handshake, optional BNE, an illegal-opcode
//                trap pulse and a retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int unsigned CNT_W   = 32,
    parameter logic        WAIT_EN = 1'b1,
    parameter logic        BNE_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       w_rdy;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_retire;
    logic       w_bne;
    logic [1:0] w_alu_op;
    logic       w_unused_funct7;

    // Only funct7[5] matters for the ALU decode.
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    // With wait states disabled the memory is treated as always ready.
    assign w_rdy = MemReady | ~WAIT_EN;
    assign w_bne = BNE_EN & (funct3 == 3'b001);

    // State, trap pulse and retire counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and Moore outputs; every instruction that completes returns to FETCH.
    always_comb begin
        state_d     = state_q;
        illegal_d   = 1'b0;
        w_retire    = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_alu_op    = 2'b00;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        case (state_q)
            S_FETCH: begin
                w_ir_write  = w_rdy;
                w_pc_update = w_rdy;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                if (w_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (Op)
                    c_OP_LOAD, c_OP_STORE: state_d = S_MEMADR;
                    c_OP_RTYPE:            state_d = S_EXECUTER;
                    c_OP_ITYPE:            state_d = S_EXECUTEI;
                    c_OP_JAL:              state_d = S_JAL;
                    c_OP_BRANCH:           state_d = S_BRANCH;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (w_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                if (w_rdy) begin
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                state_d  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
                w_retire = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Counter advances on each completed instruction and wraps naturally.
    assign retired_d = w_retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;

    // ALU operation decode from ALUOp and the instruction function fields.
    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b01:   ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (Op[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode regardless of state.
    always_comb begin
        case (Op)
            c_OP_STORE:  ImmSrc = 2'b01;
            c_OP_BRANCH: ImmSrc = 2'b10;
            c_OP_JAL:    ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    // Enables are held off for as long as reset is asserted.
    assign PCWrite   = rst & (w_pc_update | (w_branch & (Zero ^ w_bne)));
    assign MemWrite  = rst & w_mem_write;
    assign IRWrite   = rst & w_ir_write;
    assign RegWrite  = rst & w_reg_write;
    assign IllegalOp = illegal_q;
    assign Retired   = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench for multicycle_control_unit. An
//                instruction-level model expands each instruction into its
//                cycle-by-cycle expected control word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_b;
    logic [6:0] Op, funct7;
    logic [2:0] funct3;
    logic       Zero, MemReady;

    logic       a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite, a_IllegalOp;
    logic [1:0] a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc;
    logic [2:0] a_ALUControl;
    logic [31:0] a_Retired;
    logic       b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite, b_RegWrite, b_IllegalOp;
    logic [1:0] b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc;
    logic [2:0] b_ALUControl;
    logic [3:0] b_Retired;

    multicycle_control_unit u_dut_a (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .MemReady(MemReady),
        .PCWrite(a_PCWrite), .AdrSrc(a_AdrSrc), .MemWrite(a_MemWrite),
        .IRWrite(a_IRWrite), .RegWrite(a_RegWrite), .ResultSrc(a_ResultSrc),
        .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB), .ImmSrc(a_ImmSrc),
        .ALUControl(a_ALUControl), .IllegalOp(a_IllegalOp), .Retired(a_Retired)
    );

    multicycle_control_unit #(.CNT_W(4), .WAIT_EN(1'b0), .BNE_EN(1'b1)) u_dut_b (
        .clk(clk), .rst(rst_b), .Op(Op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .MemReady(1'b0),
        .PCWrite(b_PCWrite), .AdrSrc(b_AdrSrc), .MemWrite(b_MemWrite),
        .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .ResultSrc(b_ResultSrc),
        .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .ImmSrc(b_ImmSrc),
        .ALUControl(b_ALUControl), .IllegalOp(b_IllegalOp), .Retired(b_Retired)
    );

    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AW, P_J, P_B} ph_t;

    typedef struct packed {
        logic        pcw, adr, mw, irw, rw;
        logic [1:0]  res, srca, srcb, imm;
        logic [2:0]  aluc;
        logic        ill;
        logic [31:0] ret;
        logic [3:0]  retb;
        logic        bchk;
    } exp_t;

    exp_t expq[$];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_ret = 0;
    logic [3:0]  mb_ret = 0;
    logic        m_ill_pending = 1'b0;
    logic        b_on = 1'b0;
    int          ncyc, rw_cnt;
    int          ill_total = 0;
    logic        snap_pcw [0:10];
    logic [2:0]  snap_aluc [0:10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Expected control word for one cycle of a given instruction phase.
    function automatic exp_t model(input ph_t p, input logic rdy);
        exp_t e;
        logic [2:0] arith;
        e = '0;
        case (Op)
            7'b0100011: e.imm = 2'b01;
            7'b1100011: e.imm = 2'b10;
            7'b1101111: e.imm = 2'b11;
            default:    e.imm = 2'b00;
        endcase
        case (funct3)
            3'b000:  arith = (Op[5] && funct7[5]) ? 3'b001 : 3'b000;
            3'b010:  arith = 3'b101;
            3'b110:  arith = 3'b011;
            3'b111:  arith = 3'b010;
            default: arith = 3'b000;
        endcase
        case (p)
            P_F:   begin e.irw = rdy; e.pcw = rdy; e.srcb = 2'b10; e.res = 2'b10; end
            P_D:   begin e.srca = 2'b01; e.srcb = 2'b01; end
            P_MA:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            P_MR:  e.adr = 1'b1;
            P_MW:  begin e.adr = 1'b1; e.mw = 1'b1; end
            P_MWB: begin e.res = 2'b01; e.rw = 1'b1; end
            P_ER:  begin e.srca = 2'b10; e.aluc = arith; end
            P_EI:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = arith; end
            P_AW:  e.rw = 1'b1;
            P_J:   begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
            P_B:   begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = Zero ^ (funct3 == 3'b001); end
            default: e = '0;
        endcase
        e.ill  = m_ill_pending;
        e.ret  = m_ret;
        e.retb = mb_ret;
        e.bchk = b_on;
        return e;
    endfunction

    function automatic logic [18:0] ctrl_of(input exp_t e);
        return {e.pcw, e.adr, e.mw, e.irw, e.rw, e.res, e.srca, e.srcb, e.imm, e.aluc, e.ill};
    endfunction

    // One clock of stimulus: drive, queue expectation, record observations.
    task automatic cyc(input ph_t p, input logic rdy);
        MemReady = rdy;
        expq.push_back(model(p, rdy));
        m_ill_pending = 1'b0;
        #1;
        snap_pcw[int'(p)]  = a_PCWrite;
        snap_aluc[int'(p)] = a_ALUControl;
        rw_cnt    += int'(a_RegWrite);
        ill_total += int'(a_IllegalOp);
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        m_ret++;
        if (b_on) mb_ret++;
    endtask

    // Runs one whole instruction; fw/mw are fetch/memory wait cycles.
    task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input int fw, input int mw);
        Op = op; funct3 = f3; funct7 = f7; Zero = z;
        ncyc = 0; rw_cnt = 0;
        repeat (fw) cyc(P_F, 1'b0);
        cyc(P_F, 1'b1);
        cyc(P_D, 1'b1);
        case (op)
            7'b0000011: begin
                cyc(P_MA, 1'b1);
                repeat (mw) cyc(P_MR, 1'b0);
                cyc(P_MR, 1'b1);
                cyc(P_MWB, 1'b1);
                retire();
            end
            7'b0100011: begin
                cyc(P_MA, 1'b1);
                repeat (mw) cyc(P_MW, 1'b0);
                cyc(P_MW, 1'b1);
                retire();
            end
            7'b0110011: begin cyc(P_ER, 1'b1); cyc(P_AW, 1'b1); retire(); end
            7'b0010011: begin cyc(P_EI, 1'b1); cyc(P_AW, 1'b1); retire(); end
            7'b1101111: begin cyc(P_J, 1'b1);  cyc(P_AW, 1'b1); retire(); end
            7'b1100011: begin cyc(P_B, 1'b1);  retire(); end
            default:    m_ill_pending = 1'b1;
        endcase
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("a_ctrl", 32'({a_PCWrite, a_AdrSrc, a_MemWrite, a_IRWrite, a_RegWrite,
                               a_ResultSrc, a_ALUSrcA, a_ALUSrcB, a_ImmSrc, a_ALUControl,
                               a_IllegalOp}), 32'(ctrl_of(e)));
            chk("a_retired", a_Retired, e.ret);
            if (e.bchk) begin
                chk("b_ctrl", 32'({b_PCWrite, b_AdrSrc, b_MemWrite, b_IRWrite, b_RegWrite,
                                   b_ResultSrc, b_ALUSrcA, b_ALUSrcB, b_ImmSrc, b_ALUControl,
                                   b_IllegalOp}), 32'(ctrl_of(e)));
                chk("b_retired", 32'(b_Retired), 32'(e.retb));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ill_before;
        rst = 1'b0; rst_b = 1'b0;
        Op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irwrite", 32'(a_IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(a_PCWrite), 32'd0);
        chk("rst_alusrcb", 32'(a_ALUSrcB), 32'd2);
        chk("rst_retired", a_Retired, 32'd0);
        rst = 1'b1;

        exec(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0);
        chk("add_cycles", ncyc, 32'd4);
        exec(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0, 0);
        chk("sub_aluc", 32'(snap_aluc[int'(P_ER)]), 32'd1);
        chk("sub_cycles", ncyc, 32'd4);
        chk("sub_rw_pulses", rw_cnt, 32'd1);
        chk("sub_retired", a_Retired, 32'd2);
        exec(7'b0010011, 3'b000, 7'b0100000, 1'b0, 0, 0);
        exec(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 3);
        chk("lw_wait_cycles", ncyc, 32'd8);
        chk("lw_rw_pulses", rw_cnt, 32'd1);
        exec(7'b0100011, 3'b010, 7'b0000000, 1'b0, 1, 2);
        chk("sw_wait_cycles", ncyc, 32'd7);
        exec(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0);
        chk("beq_z1_pcw", 32'(snap_pcw[int'(P_B)]), 32'd1);
        chk("beq_cycles", ncyc, 32'd3);
        exec(7'b1100011, 3'b001, 7'b0000000, 1'b1, 0, 0);
        chk("bne_z1_pcw", 32'(snap_pcw[int'(P_B)]), 32'd0);
        exec(7'b1100011, 3'b001, 7'b0000000, 1'b0, 0, 0);
        chk("bne_z0_pcw", 32'(snap_pcw[int'(P_B)]), 32'd1);
        exec(7'b1100011, 3'b000, 7'b0000000, 1'b0, 0, 0);
        exec(7'b1101111, 3'b000, 7'b0000000, 1'b0, 0, 0);
        exec(7'b0110011, 3'b010, 7'b0000000, 1'b0, 0, 0);
        exec(7'b0010011, 3'b110, 7'b0000000, 1'b0, 0, 0);
        exec(7'b0110011, 3'b111, 7'b0000000, 1'b0, 0, 0);
        chk("retired_13", a_Retired, 32'd13);

        ill_before = ill_total;
        exec(7'b1111111, 3'b000, 7'b0000000, 1'b0, 0, 0);
        chk("illegal_cycles", ncyc, 32'd2);
        exec(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1, 0);
        chk("illegal_pulses", ill_total - ill_before, 32'd1);
        chk("retired_14", a_Retired, 32'd14);

        // Reset while a store is stalled in its write state.
        Op = 7'b0100011; funct3 = 3'b010; funct7 = 7'd0; Zero = 1'b0;
        cyc(P_F, 1'b1); cyc(P_D, 1'b1); cyc(P_MA, 1'b1); cyc(P_MW, 1'b0);
        chk("sw_stall_memwrite", 32'(a_MemWrite), 32'd1);
        MemReady = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_memwrite", 32'(a_MemWrite), 32'd0);
        chk("rst_irwrite2", 32'(a_IRWrite), 32'd0);
        chk("rst_adrsrc", 32'(a_AdrSrc), 32'd0);
        chk("rst_alusrcb2", 32'(a_ALUSrcB), 32'd2);
        chk("rst_retired2", a_Retired, 32'd0);
        m_ret = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exec(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0);
        chk("post_rst_retired", a_Retired, 32'd1);

        // Narrow counter, wait states disabled: 16 retirements wrap to zero.
        rst_b = 1'b1;
        b_on = 1'b1;
        mb_ret = 4'd0;
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: exec(7'b0110011, 3'b000, 7'b0000000, 1'b0, 0, 0);
                1: exec(7'b0000011, 3'b010, 7'b0000000, 1'b0, 0, 0);
                2: exec(7'b0100011, 3'b010, 7'b0000000, 1'b0, 0, 0);
                default: exec(7'b1100011, 3'b000, 7'b0000000, 1'b1, 0, 0);
            endcase
            if (i == 14) chk("b_retired_15", 32'(b_Retired), 32'd15);
        end
        chk("b_retired_wrap", 32'(b_Retired), 32'd0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation RISC-V controller for the multi-cycle datapath: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, driving shared-ALU/shared-memory mux selects.
- Adds beyond the single-cycle controller:
  - memory wait-state handshake;
  - optional BNE support;
  - illegal-opcode trap pulse;
  - retired-instruction counter.
- Sits between the instruction register (Op/funct fields) and the multi-cycle datapath.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- WAIT_EN, 1, 1 = honour MemReady; 0 = MemReady internally treated as 1.
- BNE_EN, 1, 1 = funct3=001 branches use inverted Zero; 0 = all branches behave as BEQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- Op  input  7  opcode field.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field (bit 5 used).
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access complete this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  00 = RD2, 01 = Imm, 10 = constant 4.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- IllegalOp  output  1  one-cycle pulse on unsupported opcode.
- Retired  output  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH. Encoding is free.
- Reset:
  - rst low asynchronously sets state=FETCH, Retired=0, IllegalOp=0.
  - While rst is low, all enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced 0.
  - Other outputs take FETCH values.
  - First FETCH after rst rises behaves normally.
- Handshake, with rdy = MemReady | ~WAIT_EN:
  - FETCH, MEMREAD and MEMWRITE stay put while rdy=0.
- Transitions:
  - FETCH→DECODE on rdy.
  - DECODE, by opcode:
    - 0000011 / 0100011 → MEMADR;
    - 0110011 → EXECUTER;
    - 0010011 → EXECUTEI;
    - 1101111 → JAL;
    - 1100011 → BRANCH;
    - else → FETCH with IllegalOp=1 for that cycle (registered pulse, high in the following cycle only).
  - MEMADR → MEMREAD if Op[5]=0, else MEMWRITE.
  - MEMREAD→MEMWB on rdy; MEMWB→FETCH.
  - MEMWRITE→FETCH on rdy.
  - EXECUTER, EXECUTEI, JAL → ALUWB; ALUWB→FETCH.
  - BRANCH→FETCH.
- Moore outputs: unlisted signals are 0; unlisted selects are 00.
  - FETCH: IRWrite=rdy, PCUpdate=rdy, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=01 (branch/jump target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1 every cycle in state, including wait cycles.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
  - BRANCH: ALUSrcA=10, ALUOp=01, Branch=1.
- PCWrite = PCUpdate | (Branch & (Zero ^ (BNE_EN & funct3==001))).
- ImmSrc is combinational from Op in every state:
  - load / I-type → 00; store → 01; branch → 10; jal → 11; other → 00.
- ALU decode:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10, by funct3:
    - 000 → sub if Op[5]&funct7[5], else add;
    - 010 → slt;
    - 110 → or;
    - 111 → and;
    - other → add.
- Retired:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Not incremented on the illegal-opcode return.
  - Wraps modulo 2^CNT_W.
- Latencies, in cycles with zero wait states: lw 5, sw 4, R/I 4, jal 4, branch 3.

Test Plan:
- Reset mid-MEMWRITE with MemReady=0, then rst released → MemWrite drops immediately; state=FETCH; Retired=0.
- R-type add/sub, Op=0110011, funct3=000, funct7=0100000 → ALUControl=001 in EXECUTER; RegWrite=1 in cycle 4; Retired +1.
- lw with MemReady low for 3 cycles in MEMREAD → 8 cycles total; RegWrite pulses once in MEMWB.
- Branches, BNE_EN=1:
  - BEQ with Zero=1 → PCWrite=1 in BRANCH.
  - BNE (funct3=001) with Zero=1 → PCWrite=0.
  - BNE with Zero=0 → PCWrite=1.
- Op=1111111 → IllegalOp high exactly one cycle; back to FETCH after DECODE; Retired unchanged.
- CNT_W=4: retire 16 instructions → Retired wraps to 0. WAIT_EN=0 with MemReady tied 0 → FETCH advances every time.
